// File: rtl/dense_layer_scheduler.sv
// Frame scheduler for a fixed-latency dense layer: accepts input vectors, tracks
// in-flight frames with a token pipe, and lands results in a credit-protected FIFO.
module dense_layer_scheduler #(
  parameter int WIDTH       = 17,
  parameter int INPUT_SIZE  = 32,
  parameter int OUTPUT_SIZE = 1,
  parameter int LATENCY     = 8,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic                                   enable,
  input  logic                                   in_valid,
  output logic                                   in_ready,
  input  logic [0:INPUT_SIZE-1][WIDTH-1:0]       in_data,
  output logic [0:INPUT_SIZE-1][WIDTH-1:0]       layer_in,
  input  logic [0:OUTPUT_SIZE-1][WIDTH-1:0]      layer_out,
  output logic                                   out_valid,
  input  logic                                   out_ready,
  output logic [0:OUTPUT_SIZE-1][WIDTH-1:0]      out_data,
  output logic                                   busy,
  output logic [$clog2(LATENCY+1)-1:0]           inflight
);

  localparam int CNT_W  = $clog2(LATENCY + 1);
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int FCNT_W = $clog2(FIFO_DEPTH + 1);

  typedef logic [0:OUTPUT_SIZE-1][WIDTH-1:0] res_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [LATENCY-1:0]  tok_q, tok_d;
  logic [CNT_W-1:0]    inflight_q, inflight_d;
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [FCNT_W-1:0]   fifo_cnt_q, fifo_cnt_d;
  res_t                mem_q [FIFO_DEPTH];

  logic fifo_empty;
  logic accept;
  logic push;
  logic pop;
  int   credit;

  // Credits count both queued results and frames still in the pipe, so every
  // launched frame already owns a FIFO slot by the time it lands.
  assign credit     = FIFO_DEPTH - int'(fifo_cnt_q) - int'(inflight_q);
  assign fifo_empty = (fifo_cnt_q == '0);

  assign in_ready  = (state_q == RUN) && (credit > 0);
  assign accept    = in_valid && in_ready;
  assign push      = tok_q[LATENCY-1];
  assign out_valid = !fifo_empty;
  assign pop       = out_valid && out_ready;
  assign out_data  = mem_q[rd_ptr_q];
  assign busy      = (inflight_q != '0) || !fifo_empty;
  assign inflight  = inflight_q;

  // NOTE: every variable gets a default before the case/if logic so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (enable) state_d = RUN;
      RUN:     if (!enable) state_d = DRAIN;
      DRAIN:   if ((inflight_q == '0) && fifo_empty) state_d = enable ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    // Stage 1 is filled by the accept; the token leaving stage LATENCY is the push.
    tok_d      = LATENCY'({tok_q, accept});
    inflight_d = inflight_q;
    fifo_cnt_d = fifo_cnt_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;

    if (accept && !push)      inflight_d = inflight_q + CNT_W'(1);
    else if (!accept && push) inflight_d = inflight_q - CNT_W'(1);

    if (push && !pop)      fifo_cnt_d = fifo_cnt_q + FCNT_W'(1);
    else if (!push && pop) fifo_cnt_d = fifo_cnt_q - FCNT_W'(1);

    // Power-of-two depth: pointers wrap naturally at PTR_W bits.
    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of its neighbours regardless of process order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      tok_q      <= '0;
      inflight_q <= '0;
      fifo_cnt_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
    end else begin
      state_q    <= state_d;
      tok_q      <= tok_d;
      inflight_q <= inflight_d;
      fifo_cnt_q <= fifo_cnt_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      layer_in <= '0;
    end else if (accept) begin
      layer_in <= in_data;
    end
  end

  // NOTE: the result store is reset because out_data reads it directly and
  // must show zero after reset; it is only a handful of entries.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else if (push) begin
      mem_q[wr_ptr_q] <= layer_out;
    end
  end

endmodule

// File: tb/tb_dense_layer_scheduler.sv
// Directed bench for dense_layer_scheduler: a default instance (LATENCY=8, depth 4)
// and a short-latency instance (LATENCY=3), each fed by a behavioural layer model.
module tb_dense_layer_scheduler;

  typedef logic [0:31][16:0] vec_t;
  typedef logic [0:0][16:0]  res_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // Default instance signals
  logic       enable, in_valid, in_ready, out_valid, out_ready, busy;
  vec_t       in_data, layer_in;
  res_t       layer_out, out_data;
  logic [3:0] inflight;

  // Short-latency instance signals
  logic       enable3, in_valid3, in_ready3, out_valid3, out_ready3, busy3;
  vec_t       in_data3, layer_in3;
  res_t       layer_out3, out_data3;
  logic [1:0] inflight3;

  dense_layer_scheduler dut (
    .clk(clk), .reset(reset), .enable(enable), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .layer_in(layer_in), .layer_out(layer_out), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .busy(busy), .inflight(inflight)
  );

  dense_layer_scheduler #(.LATENCY(3), .FIFO_DEPTH(4)) dut3 (
    .clk(clk), .reset(reset), .enable(enable3), .in_valid(in_valid3), .in_ready(in_ready3),
    .in_data(in_data3), .layer_in(layer_in3), .layer_out(layer_out3), .out_valid(out_valid3),
    .out_ready(out_ready3), .out_data(out_data3), .busy(busy3), .inflight(inflight3)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Layer model: result = first element XOR last element, visible LATENCY cycles
  // after layer_in changes.
  function automatic logic [16:0] layer_fn(input vec_t v);
    return v[0] ^ v[31];
  endfunction

  function automatic vec_t mk(input logic [16:0] id);
    vec_t v;
    for (int i = 0; i < 32; i++) v[i] = 17'(id + 17'(i));
    v[0]  = id;
    v[31] = 17'h10000;
    return v;
  endfunction

  logic [16:0] lp8 [0:6];
  logic [16:0] lp3 [0:1];
  always @(posedge clk) begin
    lp8[0] <= layer_fn(layer_in);
    for (int i = 1; i < 7; i++) lp8[i] <= lp8[i-1];
    lp3[0] <= layer_fn(layer_in3);
    lp3[1] <= lp3[0];
  end
  assign layer_out[0]  = lp8[6];
  assign layer_out3[0] = lp3[1];

  // Scoreboards
  logic [16:0] exp_q[$];
  logic [16:0] exp3_q[$];
  int          acc3_cyc_q[$];
  int acc_cnt = 0, pop_cnt = 0, acc3 = 0, pop3 = 0, ovf = 0, cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (reset) begin
      if (in_valid && in_ready) begin
        exp_q.push_back(layer_fn(in_data));
        acc_cnt++;
      end
      if (out_valid && out_ready) begin
        pop_cnt++;
        if (exp_q.size() == 0) check("pop_unexpected", 32'd1, 32'd0);
        else                   check("pop_data", 32'(out_data[0]), 32'(exp_q.pop_front()));
      end
      if (dut.push && !dut.pop && (dut.fifo_cnt_q == 3'd4)) ovf++;

      if (in_valid3 && in_ready3) begin
        exp3_q.push_back(layer_fn(in_data3));
        acc3_cyc_q.push_back(cyc);
        acc3++;
      end
      if (out_valid3 && out_ready3) begin
        pop3++;
        if (exp3_q.size() == 0) check("t2_pop_unexpected", 32'd1, 32'd0);
        else begin
          check("t2_data", 32'(out_data3[0]), 32'(exp3_q.pop_front()));
          // Pushed 3 edges after accept, popped on the following edge.
          check("t2_offset", 32'(cyc - acc3_cyc_q.pop_front()), 32'd4);
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic wait_idle(input string tag);
    for (int n = 0; n < 60 && busy; n++) step(1);
    check(tag, 32'(busy), 32'd0);
  endtask

  initial begin
    int base_acc, base_pop;
    reset = 1'b1;
    enable = 0; in_valid = 0; out_ready = 0; in_data = '0;
    enable3 = 0; in_valid3 = 0; out_ready3 = 0; in_data3 = '0;
    #2 reset = 1'b0;
    @(negedge clk);

    // Reset state
    check("rst_in_ready",  32'(in_ready),    32'd0);
    check("rst_out_valid", 32'(out_valid),   32'd0);
    check("rst_out_data",  32'(out_data[0]), 32'd0);
    check("rst_busy",      32'(busy),        32'd0);
    check("rst_inflight",  32'(inflight),    32'd0);
    check("rst_layer_in",  32'(layer_in[5]), 32'd0);
    reset = 1'b1;
    step(2);
    check("idle_in_ready", 32'(in_ready), 32'd0);

    // Test 1: single frame, push LATENCY edges after accept
    enable = 1;
    step(1);
    check("t1_in_ready", 32'(in_ready), 32'd1);
    in_valid = 1; in_data = mk(17'h00001);
    step(1);
    in_valid = 0;
    check("t1_inflight0", 32'(inflight),    32'd1);
    check("t1_layer_in",  32'(layer_in[0]), 32'd1);
    for (int k = 1; k < 8; k++) begin
      step(1);
      check("t1_inflight",  32'(inflight),  32'd1);
      check("t1_out_valid", 32'(out_valid), 32'd0);
    end
    step(1);
    check("t1_inflight_end", 32'(inflight),    32'd0);
    check("t1_valid",        32'(out_valid),   32'd1);
    check("t1_data",         32'(out_data[0]), 32'h10001);
    check("t1_busy",         32'(busy),        32'd1);
    out_ready = 1;
    step(1);
    check("t1_popped", 32'(out_valid), 32'd0);
    check("t1_idle",   32'(busy),      32'd0);

    // Test 3: back-pressure, credits stop intake at FIFO_DEPTH frames
    out_ready = 0;
    base_acc = acc_cnt;
    for (int i = 0; i < 20; i++) begin
      in_valid = 1; in_data = mk(17'(17'h00100 + 17'(i * 7)));
      step(1);
    end
    in_valid = 0;
    check("t3_accepts",   32'(acc_cnt - base_acc), 32'd4);
    check("t3_in_ready",  32'(in_ready),           32'd0);
    check("t3_out_valid", 32'(out_valid),          32'd1);
    check("t3_inflight",  32'(inflight),           32'd0);
    check("t3_full",      32'(dut.fifo_cnt_q),     32'd4);
    base_pop = pop_cnt;
    out_ready = 1;
    wait_idle("t3_drain");
    check("t3_pops", 32'(pop_cnt - base_pop), 32'd4);

    // Test 6: push and pop on the same edge keep the count; order across wrap
    out_ready = 0;
    base_pop = pop_cnt;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1; in_data = mk(17'(17'h1ABC0 + 17'(i)));
      step(1);
    end
    in_valid = 0;
    step(7);
    check("t6_cnt_before", 32'(dut.fifo_cnt_q), 32'd3);
    check("t6_infl_before", 32'(inflight),      32'd1);
    out_ready = 1;
    step(1);
    check("t6_cnt_after",  32'(dut.fifo_cnt_q), 32'd3);
    check("t6_infl_after", 32'(inflight),       32'd0);
    wait_idle("t6_drain");
    check("t6_pops", 32'(pop_cnt - base_pop), 32'd4);

    // Test 4: drop enable with 3 frames in flight
    base_acc = acc_cnt;
    base_pop = pop_cnt;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1; in_data = mk(17'(17'h0F0F0 + 17'(i)));
      step(1);
    end
    in_valid = 0; enable = 0;
    check("t4_inflight", 32'(inflight), 32'd3);
    step(1);
    check("t4_in_ready", 32'(in_ready), 32'd0);
    check("t4_busy",     32'(busy),     32'd1);
    in_valid = 1; in_data = mk(17'h05555);
    wait_idle("t4_drain");
    in_valid = 0;
    check("t4_accepts", 32'(acc_cnt - base_acc), 32'd3);
    check("t4_pops",    32'(pop_cnt - base_pop), 32'd3);
    step(1);
    check("t4_state_idle", 32'(dut.state_q), 32'd0);
    check("t4_idle_ready", 32'(in_ready),    32'd0);

    // Test 5: reset with 2 frames in flight and 1 queued
    enable = 1; out_ready = 0;
    step(1);
    in_valid = 1; in_data = mk(17'h00A00); step(1);
    in_valid = 0; step(4);
    in_valid = 1; in_data = mk(17'h00B00); step(1);
    in_data = mk(17'h00C00); step(1);
    in_valid = 0; step(2);
    check("t5_inflight", 32'(inflight),  32'd2);
    check("t5_queued",   32'(out_valid), 32'd1);
    #2 reset = 1'b0;
    #1;
    exp_q.delete();
    check("t5_rst_valid",    32'(out_valid),   32'd0);
    check("t5_rst_data",     32'(out_data[0]), 32'd0);
    check("t5_rst_inflight", 32'(inflight),    32'd0);
    check("t5_rst_busy",     32'(busy),        32'd0);
    check("t5_rst_ready",    32'(in_ready),    32'd0);
    check("t5_rst_layer_in", 32'(layer_in[0]), 32'd0);
    @(negedge clk);
    reset = 1'b1; enable = 0;
    step(12);
    check("t5_no_stray_valid", 32'(out_valid), 32'd0);
    check("t5_no_stray_busy",  32'(busy),      32'd0);
    check("t5_no_stray_infl",  32'(inflight),  32'd0);

    // Test 2: LATENCY=3 instance, streaming with out_ready held high
    enable3 = 1;
    step(1);
    in_valid3 = 1; out_ready3 = 1;
    for (int n = 0; n < 100 && acc3 < 20; n++) begin
      in_data3 = mk(17'(17'h00200 + 17'(acc3 * 5)));
      step(1);
    end
    in_valid3 = 0;
    for (int n = 0; n < 30 && busy3; n++) step(1);
    check("t2_idle",    32'(busy3), 32'd0);
    check("t2_accepts", 32'(acc3),  32'd20);
    check("t2_pops",    32'(pop3),  32'd20);

    check("no_full_push", 32'(ovf), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
